// File: rtl/pipes_pkg.sv
// Shared pipeline types: memory access sizes and the memory-port arbiter encodings.
package pipes;

    typedef enum logic [2:0] {
        MSize_8bits  = 3'd0,
        MSize_16bits = 3'd1,
        MSize_32bits = 3'd2,
        MSize_64bits = 3'd3
    } MemSizeType;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_I    = 2'd1,
        GRANT_D    = 2'd2
    } arb_grant_t;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts data grants won while a fetch was waiting; saturates at STARVE_LIMIT.
module arb_starve_counter
    import pipes::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic full
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single 64-bit memory port between instruction fetch and data access.
// Data side has priority; a starvation counter forces a fetch grant eventually.
module mem_port_arbiter
    import pipes::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    input  logic        i_flush,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [63:0] d_addr,
    input  logic        d_write,
    input  logic [2:0]  d_size,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_strobe,
    output logic        d_data_ok,
    output logic [63:0] d_rdata,
    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic        m_write,
    output logic [2:0]  m_size,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_strobe,
    input  logic        m_ready,
    input  logic [63:0] m_rdata
);

    arb_state_t  state_q, state_d;
    arb_grant_t  grant;
    logic        i_want;
    logic        starve_full;
    logic        starve_inc;
    logic        starve_clr;

    logic        m_valid_q, m_valid_d;
    logic [63:0] m_addr_q, m_addr_d;
    logic        m_write_q, m_write_d;
    logic [2:0]  m_size_q, m_size_d;
    logic [63:0] m_wdata_q, m_wdata_d;
    logic [7:0]  m_strobe_q, m_strobe_d;
    logic        i_data_ok_q, i_data_ok_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_data_ok_q, d_data_ok_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        drop_q, drop_d;

    assign i_want     = i_req & ~i_flush;
    assign starve_inc = (grant == GRANT_D) & i_want;
    assign starve_clr = (grant == GRANT_I);

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clear (starve_clr),
        .full  (starve_full)
    );

    // State register, plus all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_write_q   <= 1'b0;
            m_size_q    <= '0;
            m_wdata_q   <= '0;
            m_strobe_q  <= '0;
            i_data_ok_q <= 1'b0;
            i_rdata_q   <= '0;
            d_data_ok_q <= 1'b0;
            d_rdata_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_write_q   <= m_write_d;
            m_size_q    <= m_size_d;
            m_wdata_q   <= m_wdata_d;
            m_strobe_q  <= m_strobe_d;
            i_data_ok_q <= i_data_ok_d;
            i_rdata_q   <= i_rdata_d;
            d_data_ok_q <= d_data_ok_d;
            d_rdata_q   <= d_rdata_d;
            drop_q      <= drop_d;
        end
    end

    // Grant decision (IDLE only) and next-state logic.
    always_comb begin
        grant = GRANT_NONE;
        if (state_q == IDLE) begin
            if (i_want && starve_full) begin
                grant = GRANT_I;
            end else if (d_req) begin
                grant = GRANT_D;
            end else if (i_want) begin
                grant = GRANT_I;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant == GRANT_I) begin
                    state_d = BUSY_I;
                end else if (grant == GRANT_D) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: latch on grant, hold while busy, capture on m_ready.
    always_comb begin
        m_valid_d   = m_valid_q;
        m_addr_d    = m_addr_q;
        m_write_d   = m_write_q;
        m_size_d    = m_size_q;
        m_wdata_d   = m_wdata_q;
        m_strobe_d  = m_strobe_q;
        i_data_ok_d = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_data_ok_d = 1'b0;
        d_rdata_d   = d_rdata_q;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                if (grant == GRANT_I) begin
                    m_valid_d  = 1'b1;
                    m_addr_d   = i_addr;
                    m_write_d  = 1'b0;
                    m_size_d   = MSize_32bits;
                    m_wdata_d  = '0;
                    m_strobe_d = '0;
                end else if (grant == GRANT_D) begin
                    m_valid_d  = 1'b1;
                    m_addr_d   = d_addr;
                    m_write_d  = d_write;
                    m_size_d   = d_size;
                    m_wdata_d  = d_wdata;
                    m_strobe_d = d_strobe;
                end
            end
            BUSY_I: begin
                // A flush on the completing cycle must also suppress the pulse,
                // so the incoming flush is folded in alongside drop_q.
                drop_d = drop_q | i_flush;
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    i_rdata_d   = m_addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
                    i_data_ok_d = ~(drop_q | i_flush);
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    d_rdata_d   = m_rdata;
                    d_data_ok_d = 1'b1;
                end
            end
            RESP: begin
                drop_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_write   = m_write_q;
    assign m_size    = m_size_q;
    assign m_wdata   = m_wdata_q;
    assign m_strobe  = m_strobe_q;
    assign i_data_ok = i_data_ok_q;
    assign i_rdata   = i_rdata_q;
    assign d_data_ok = d_data_ok_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with STARVE_LIMIT = 2.
module tb_mem_port_arbiter;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_flush, i_data_ok;
    logic [63:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_write, d_data_ok;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic        m_valid, m_write, m_ready;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
        .d_wdata(d_wdata), .d_strobe(d_strobe),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_size(m_size),
        .m_wdata(m_wdata), .m_strobe(m_strobe),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle trace for the starvation run.
    logic        sv_valid [12];
    logic [63:0] sv_addr  [12];
    logic        sv_dok   [12];
    logic        sv_iok   [12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_req = 0; i_addr = '0; i_flush = 0;
        d_req = 0; d_addr = '0; d_write = 0; d_size = '0; d_wdata = '0; d_strobe = '0;
        m_ready = 0; m_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_i_ok", 64'(i_data_ok), 0);
        check("rst_d_ok", 64'(d_data_ok), 0);
        check("rst_i_rdata", 64'(i_rdata), 0);
        check("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;
        tick();

        // Single fetch, minimum latency
        i_req = 1; i_addr = 64'h8000_0004;
        tick();
        check("f_valid", 64'(m_valid), 1);
        check("f_addr", m_addr, 64'h8000_0004);
        check("f_write", 64'(m_write), 0);
        check("f_size", 64'(m_size), 64'(MSize_32bits));
        check("f_strobe", 64'(m_strobe), 0);
        check("f_iok_early", 64'(i_data_ok), 0);
        m_ready = 1; m_rdata = 64'h1122_3344_5566_7788;
        tick();
        check("f_iok", 64'(i_data_ok), 1);
        check("f_rdata", 64'(i_rdata), 64'h1122_3344);
        check("f_valid_drop", 64'(m_valid), 0);
        i_req = 0; m_ready = 0;
        tick();
        check("f_iok_pulse", 64'(i_data_ok), 0);

        // Contention: data wins, then fetch
        i_req = 1; i_addr = 64'h1000;
        d_req = 1; d_addr = 64'h100; d_write = 1; d_strobe = 8'hFF;
        d_size = MSize_64bits; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        check("c_d_addr", m_addr, 64'h100);
        check("c_d_write", 64'(m_write), 1);
        check("c_d_strobe", 64'(m_strobe), 64'hFF);
        check("c_d_wdata", m_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        m_ready = 1; m_rdata = 64'hAAAA_5555_0F0F_F0F0;
        tick();
        check("c_dok", 64'(d_data_ok), 1);
        check("c_iok_none", 64'(i_data_ok), 0);
        check("c_d_rdata", d_rdata, 64'hAAAA_5555_0F0F_F0F0);
        d_req = 0; m_ready = 0;
        tick();
        check("c_idle_valid", 64'(m_valid), 0);
        tick();
        check("c_i_valid", 64'(m_valid), 1);
        check("c_i_addr", m_addr, 64'h1000);
        check("c_i_write", 64'(m_write), 0);
        check("c_i_strobe", 64'(m_strobe), 0);
        m_ready = 1; m_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        check("c_iok", 64'(i_data_ok), 1);
        check("c_i_rdata", 64'(i_rdata), 64'h89AB_CDEF);
        i_req = 0; m_ready = 0;
        tick();

        // Starvation with limit 2: D, D, I, then D again (counter cleared)
        sv_valid = '{1,0,0, 1,0,0, 1,0,0, 1,0,0};
        sv_addr  = '{64'h300,64'h300,64'h300, 64'h300,64'h300,64'h300,
                     64'h2004,64'h2004,64'h2004, 64'h300,64'h300,64'h300};
        sv_dok   = '{0,1,0, 0,1,0, 0,0,0, 0,1,0};
        sv_iok   = '{0,0,0, 0,0,0, 0,1,0, 0,0,0};
        i_req = 1; i_addr = 64'h2004;
        d_req = 1; d_addr = 64'h300; d_write = 0; d_strobe = 0; d_size = MSize_64bits;
        m_ready = 1; m_rdata = 64'hCAFE_BABE_0000_0001;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("s_valid%0d", k), 64'(m_valid), 64'(sv_valid[k]));
            check($sformatf("s_addr%0d", k), m_addr, sv_addr[k]);
            check($sformatf("s_dok%0d", k), 64'(d_data_ok), 64'(sv_dok[k]));
            check($sformatf("s_iok%0d", k), 64'(i_data_ok), 64'(sv_iok[k]));
            if (k == 7) check("s_i_rdata", 64'(i_rdata), 64'hCAFE_BABE);
            if (k == 9) begin
                i_req = 0; d_req = 0;
            end
        end
        m_ready = 0;

        // Flush while fetch in flight
        i_req = 1; i_addr = 64'h3000;
        tick();
        check("fl_valid", 64'(m_valid), 1);
        i_flush = 1;
        tick();
        i_flush = 0; i_req = 0;
        tick();
        check("fl_hold", 64'(m_valid), 1);
        m_ready = 1; m_rdata = 64'h5;
        tick();
        check("fl_done_valid", 64'(m_valid), 0);
        check("fl_no_iok", 64'(i_data_ok), 0);
        m_ready = 0;
        i_req = 1; i_addr = 64'h4004;
        tick();
        check("fl_resp_iok", 64'(i_data_ok), 0);
        tick();
        check("fl_new_addr", m_addr, 64'h4004);
        m_ready = 1; m_rdata = 64'h7777_6666_5555_4444;
        tick();
        check("fl_new_iok", 64'(i_data_ok), 1);
        check("fl_new_rdata", 64'(i_rdata), 64'h7777_6666);
        i_req = 0; m_ready = 0;
        tick();

        // Stalled memory: fields stay put even if the requester's inputs move
        d_req = 1; d_addr = 64'h500; d_write = 1; d_wdata = 64'h0102_0304_0506_0708;
        d_strobe = 8'h0F; d_size = MSize_32bits;
        tick();
        d_addr = 64'hFFF0; d_wdata = '1; d_strobe = 8'hF0; d_size = MSize_8bits;
        for (int k = 0; k < 10; k++) begin
            check("st_addr", m_addr, 64'h500);
            check("st_wdata", m_wdata, 64'h0102_0304_0506_0708);
            check("st_strobe", 64'(m_strobe), 64'h0F);
            check("st_size", 64'(m_size), 64'(MSize_32bits));
            check("st_dok", 64'(d_data_ok), 0);
            tick();
        end

        // Reset mid-transaction (still BUSY_D)
        check("rm_valid_before", 64'(m_valid), 1);
        reset = 1'b0;
        #1;
        check("rm_valid", 64'(m_valid), 0);
        check("rm_addr", m_addr, 0);
        check("rm_dok", 64'(d_data_ok), 0);
        check("rm_iok", 64'(i_data_ok), 0);
        #2;
        reset = 1'b1;
        d_addr = 64'h500; d_wdata = 64'h0102_0304_0506_0708; d_strobe = 8'h0F; d_size = MSize_32bits;
        tick();
        check("rm_regrant_valid", 64'(m_valid), 1);
        check("rm_regrant_addr", m_addr, 64'h500);
        m_ready = 1; m_rdata = 64'h9999_8888_7777_6666;
        tick();
        check("rm_dok", 64'(d_data_ok), 1);
        check("rm_store_rdata", d_rdata, 64'h9999_8888_7777_6666);
        d_req = 0; m_ready = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single 64-bit memory port between the fetch stage (instruction bus) and the memory stage (data bus).
- Fixed priority to the data side (older instruction), with a starvation limit that guarantees fetch progress.
- Registers the granted request, holds it stable on the memory port until accepted, then returns a one-cycle response pulse to the winner.
- Sits between the pipeline stages and the memory/cache interface.

Parameters:
STARVE_LIMIT, 4, consecutive data grants lost by a waiting fetch before fetch is forced to win (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held until i_data_ok
i_addr  in  64  fetch address, 4-byte aligned
i_flush  in  1  fetch redirect; current or pending fetch response is discarded
i_data_ok  out  1  one-cycle fetch completion pulse
i_rdata  out  32  instruction word
d_req  in  1  data request; held until d_data_ok
d_addr  in  64  data address
d_write  in  1  1 = store, 0 = load
d_size  in  3  MemSizeType
d_wdata  in  64  store data, lane-aligned
d_strobe  in  8  byte enables (0 for loads)
d_data_ok  out  1  one-cycle data completion pulse
d_rdata  out  64  load data (raw 64-bit doubleword)
m_valid  out  1  memory request valid
m_addr  out  64  memory address
m_write  out  1  memory write
m_size  out  3  MemSizeType
m_wdata  out  64  memory write data
m_strobe  out  8  memory byte enables
m_ready  in  1  memory accepted and completed; m_rdata valid same cycle
m_rdata  in  64  memory read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- Reset values: state IDLE, all m_* outputs 0, i_data_ok = d_data_ok = 0, i_rdata = d_rdata = 0, starve_cnt = 0, drop = 0.
- IDLE grant rule:
  - If i_req & !i_flush & starve_cnt == STARVE_LIMIT: grant I.
  - Else if d_req: grant D; starve_cnt increments (saturating) if i_req & !i_flush was also high.
  - Else if i_req & !i_flush: grant I.
  - Granting I clears starve_cnt.
- On grant, request fields are latched into the m_* registers and m_valid rises the next cycle. I-grants drive m_write = 0, m_size = MSize_32bits, m_strobe = 0, m_wdata = 0.
- BUSY_x: m_* fields are held stable. m_ready is ignored outside BUSY_x.
- On m_ready in BUSY_x, in the same edge: capture m_rdata, drop m_valid, go to RESP.
  - i_rdata = latched addr[2] ? m_rdata[63:32] : m_rdata[31:0].
  - d_rdata = m_rdata, also captured for stores.
- RESP lasts one cycle: asserts i_data_ok or d_data_ok, then returns to IDLE. No grant is made in RESP, so a requester still holding req that cycle is not re-granted.
- Minimum latency: request visible at cycle t, m_valid at t+1, m_ready at t+1, data_ok at t+2.
- i_flush:
  - Sampled high while BUSY_I, or in the IDLE cycle that grants I, sets drop.
  - The bus transaction still completes (no abort).
  - In RESP, drop suppresses i_data_ok; drop clears on leaving RESP.
  - i_flush has no effect on D transactions.
- Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: D wins.
- Reset mid-transaction: immediate return to reset values; the outstanding memory access is abandoned and m_valid drops asynchronously.

Decomposition:
- Package pipes gains `arb_state_t` (IDLE, BUSY_I, BUSY_D, RESP) and `arb_grant_t` (GRANT_NONE, GRANT_I, GRANT_D).
- Reuses the package's existing MemSizeType; arb_grant_t gets a fixed 2-bit width.
- One natural sub-module: `arb_starve_counter`, a saturating 4-bit counter with inc/clear/full outputs, parameterised by STARVE_LIMIT.

Test Plan:
- Single fetch: i_req = 1 with i_addr = 0x8000_0004; m_ready = 1 the cycle after m_valid, m_rdata = 0x1122334455667788 -> m_addr = 0x80000004, i_rdata = 0x11223344, i_data_ok pulses exactly 1 cycle, 2 cycles after request.
- Contention: i_req and d_req both high, d_addr = 0x100, d_write = 1, d_strobe = 0xFF -> D granted first with m_write = 1 and m_strobe = 0xFF; I granted after d_data_ok.
- Starvation, STARVE_LIMIT = 2: d_req held continuously with back-to-back transactions, i_req high -> after 2 D grants the 3rd grant is I; starve_cnt then 0.
- Flush in flight: grant I, assert i_flush during BUSY_I, m_ready after 3 cycles -> transaction completes on bus, no i_data_ok, next IDLE grants a new I request normally.
- Reset mid-op: reset low during BUSY_D with m_valid = 1 -> m_valid = 0 and all pulses 0 immediately; after release a d_req is re-granted from IDLE.
- Stalled memory: m_ready held low 10 cycles -> m_addr, m_wdata, m_strobe and m_size unchanged every cycle, no data_ok.
